// File: rtl/axi_sram_read_burst.sv
// AXI read-channel slave: turns AR/R bursts (FIXED/INCR/WRAP) into single-cycle
// synchronous SRAM reads, one beat per cycle, with SLVERR beats for illegal requests.
module axi_sram_read_burst #(
  parameter int unsigned IDW    = 8,
  parameter int unsigned ADDRW  = 32,
  parameter int unsigned DATAW  = 32,
  parameter int unsigned LENW   = 4,
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDW-1:0]    ARID,
  input  logic [ADDRW-1:0]  ARADDR,
  input  logic [LENW-1:0]   ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [IDW-1:0]    RID,
  output logic [DATAW-1:0]  RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              rd_grant,
  output logic              finish,
  output logic [MEM_AW-1:0] Address,
  output logic              ReadEnable,
  input  logic [DATAW-1:0]  DataRead
);

  localparam int unsigned OFF         = $clog2(DATAW / 8);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;

  typedef enum logic {IDLE, DATA} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    id, id_nxt;
  logic [ADDRW-1:0]  cur_addr, cur_addr_nxt;
  logic [LENW-1:0]   beats_left, beats_left_nxt;
  logic [LENW-1:0]   len, len_nxt;
  logic [2:0]        size, size_nxt;
  logic [1:0]        burst, burst_nxt;
  logic              err, err_nxt;

  logic              req_err;
  logic              wrap_len_ok;
  logic [ADDRW-1:0]  beat_bytes;
  logic [ADDRW-1:0]  wrap_mask;
  logic [ADDRW-1:0]  incr_addr;
  logic [ADDRW-1:0]  next_addr;

  // Truncating casts fold 7/15 to all-ones for narrow LENW, which stays in the legal set.
  always_comb begin
    wrap_len_ok = (ARLEN == LENW'(1)) || (ARLEN == LENW'(3)) ||
                  (ARLEN == LENW'(7)) || (ARLEN == LENW'(15));
    req_err     = (ARBURST == BURST_RSVD) || (ARSIZE > 3'(OFF)) ||
                  ((ARBURST == BURST_WRAP) && !wrap_len_ok);
  end

  // Address of the following beat; carry out of ADDRW is discarded.
  always_comb begin
    beat_bytes = ADDRW'(1) << size;
    wrap_mask  = ((ADDRW'(len) + ADDRW'(1)) << size) - ADDRW'(1);
    incr_addr  = cur_addr + beat_bytes;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      id         <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      len        <= '0;
      size       <= '0;
      burst      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      id         <= id_nxt;
      cur_addr   <= cur_addr_nxt;
      beats_left <= beats_left_nxt;
      len        <= len_nxt;
      size       <= size_nxt;
      burst      <= burst_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    id_nxt         = id;
    cur_addr_nxt   = cur_addr;
    beats_left_nxt = beats_left;
    len_nxt        = len;
    size_nxt       = size;
    burst_nxt      = burst;
    err_nxt        = err;
    ARREADY        = 1'b0;
    RVALID         = 1'b0;
    RID            = '0;
    RDATA          = '0;
    RRESP          = RESP_OKAY;
    RLAST          = 1'b0;
    finish         = 1'b0;
    ReadEnable     = 1'b0;
    Address        = '0;
    case (state)
      IDLE: begin
        ARREADY = rd_grant;
        if (ARVALID && rd_grant && reset) begin
          state_nxt      = DATA;
          id_nxt         = ARID;
          cur_addr_nxt   = ARADDR;
          beats_left_nxt = ARLEN;
          len_nxt        = ARLEN;
          size_nxt       = ARSIZE;
          burst_nxt      = ARBURST;
          err_nxt        = req_err;
          if (!req_err) begin
            ReadEnable = 1'b1;
            Address    = ARADDR[MEM_AW+OFF-1:OFF];
          end
        end
      end
      DATA: begin
        RVALID = 1'b1;
        RID    = id;
        RRESP  = err ? RESP_SLVERR : RESP_OKAY;
        RDATA  = err ? '0 : DataRead;
        RLAST  = (beats_left == '0);
        if (RREADY) begin
          if (beats_left == '0) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            beats_left_nxt = beats_left - LENW'(1);
            cur_addr_nxt   = next_addr;
            if (!err) begin
              ReadEnable = 1'b1;
              Address    = next_addr[MEM_AW+OFF-1:OFF];
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_read_burst.sv
// Randomized bench for axi_sram_read_burst: an SRAM model plus a per-burst
// reference that lists expected beat addresses, data and responses arithmetically.
module tb_axi_sram_read_burst;

  logic        clock;
  logic        reset;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        rd_grant;
  logic        finish;
  logic [13:0] Address;
  logic        ReadEnable;
  logic [31:0] DataRead;

  logic [31:0] mem [0:16383];
  int n_tests = 0;
  int n_fail  = 0;

  axi_sram_read_burst dut (
    .clock(clock), .reset(reset),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY), .rd_grant(rd_grant), .finish(finish),
    .Address(Address), .ReadEnable(ReadEnable), .DataRead(DataRead)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM: output valid the cycle after the strobe, held otherwise.
  always @(posedge clock) if (ReadEnable) DataRead <= mem[Address];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] idx(input logic [31:0] a);
    return a[15:2];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rvalid"}, RVALID, 0);
    check_eq({tag, "_rlast"}, RLAST, 0);
    check_eq({tag, "_finish"}, finish, 0);
    check_eq({tag, "_re"}, ReadEnable, 0);
    check_eq({tag, "_addr"}, Address, 0);
    check_eq({tag, "_rid"}, RID, 0);
    check_eq({tag, "_rdata"}, RDATA, 0);
    check_eq({tag, "_rresp"}, RRESP, 0);
    check_eq({tag, "_arready"}, ARREADY, rd_grant);
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int grant_delay,
                           input int stall_beat, input int stall_cycles, input bit rand_stall);
    logic [31:0] a [$];
    logic [31:0] w, base, bytes, exp_data;
    bit err;
    bit nxt;
    int nst;
    err = (burst == 3) || (size > 2) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    bytes = 32'(1) << size;
    w     = 32'(len + 1) * bytes;
    base  = (w != 0) ? addr - (addr % w) : addr;
    for (int k = 0; k <= len; k++) begin
      case (burst)
        0:       a.push_back(addr);
        1:       a.push_back(addr + 32'(k) * bytes);
        2:       a.push_back(err ? addr : base + (((addr % w) + 32'(k) * bytes) % w));
        default: a.push_back(addr);
      endcase
    end
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size);
    ARBURST = 2'(burst); ARVALID = 1'b1; rd_grant = 1'b0; RREADY = 1'b0;
    for (int g = 0; g < grant_delay; g++) begin
      @(negedge clock);
      check_eq("arready_nogrant", ARREADY, 0);
      check_eq("rvalid_nogrant", RVALID, 0);
      check_eq("re_nogrant", ReadEnable, 0);
      @(posedge clock); #1;
    end
    rd_grant = 1'b1;
    @(negedge clock);
    check_eq("arready_grant", ARREADY, 1);
    check_eq("rvalid_ar", RVALID, 0);
    check_eq("re_ar", ReadEnable, !err);
    check_eq("addr_ar", Address, err ? 14'd0 : idx(a[0]));
    @(posedge clock); #1;
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    ARID    = 8'($urandom);
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat) nst = stall_cycles;
      else if (rand_stall && $urandom_range(0, 3) == 0) nst = $urandom_range(1, 2);
      else nst = 0;
      exp_data = err ? 32'd0 : mem[idx(a[b])];
      for (int s = 0; s <= nst; s++) begin
        RREADY   = (s == nst);
        rd_grant = 1'($urandom_range(0, 1));
        @(negedge clock);
        check_eq("rvalid", RVALID, 1);
        check_eq("arready_data", ARREADY, 0);
        check_eq("rid", RID, id);
        check_eq("rresp", RRESP, err ? 2'b10 : 2'b00);
        check_eq("rlast", RLAST, b == len);
        check_eq("rdata", RDATA, exp_data);
        if (RREADY) begin
          nxt = !err && (b < len);
          check_eq("finish", finish, b == len);
          check_eq("re_beat", ReadEnable, nxt);
          check_eq("addr_beat", Address, nxt ? idx(a[b+1]) : 14'd0);
        end else begin
          check_eq("finish_stall", finish, 0);
          check_eq("re_stall", ReadEnable, 0);
        end
        @(posedge clock); #1;
      end
    end
    RREADY = 1'b0;
    rd_grant = 1'b0;
    @(negedge clock);
    check_eq("rvalid_after", RVALID, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    reset = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARVALID = 1'b0; RREADY = 1'b0; rd_grant = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    run_burst(8'h11, 32'h100, 3, 2, 1, 0, -1, 0, 1'b0);
    run_burst(8'h22, 32'h38, 3, 2, 2, 0, -1, 0, 1'b0);
    run_burst(8'h33, 32'h1234, 2, 2, 0, 0, 1, 3, 1'b0);
    run_burst(8'h44, 32'h80, 1, 2, 3, 0, -1, 0, 1'b0);
    run_burst(8'h55, 32'h200, 0, 2, 1, 3, -1, 0, 1'b0);
    run_burst(8'h66, 32'h40, 2, 3, 1, 0, -1, 0, 1'b0);
    run_burst(8'h77, 32'h40, 2, 2, 2, 0, -1, 0, 1'b0);
    run_burst(8'h88, 32'hFFFF_FFFC, 2, 2, 1, 0, -1, 0, 1'b0);

    // Reset during beat 2 of a 4-beat burst.
    ARID = 8'h5A; ARADDR = 32'h300; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1; rd_grant = 1'b1; RREADY = 1'b1;
    @(posedge clock); #1;
    ARVALID = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("rst_pre_rvalid", RVALID, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge clock); #1;
    RREADY = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_post_rvalid", RVALID, 0);
    @(posedge clock); #1;
    run_burst(8'hA5, 32'h400, 3, 2, 1, 0, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_burst(8'($urandom), $urandom, $urandom_range(0, 15),
                ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 2), -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
